hazard_detection_unit: RTL
==========================

Name: hazard_detection_unit

Overview:
- Control-side partner of the ID/EXE pipeline register: generates the `flush` and `freeze` controls that register and the IF stage consume.
- Keeps a shadow copy of the destination and write-enable info in flight in the EXE and MEM stages.
- Flags RAW hazards against the instruction currently in ID, squashes instructions on a taken branch, and stalls everything while data memory is busy.
- Counts stall cycles for performance measurement.

Parameters:
- FORWARD_EN, 0, 0 = stall on any RAW match in EXE or MEM; 1 = stall only on a load-use match in EXE (forwarding covers the rest).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  4  first source register
- id_src2  in  4  second source register
- id_two_src  in  1  id_src2 is actually read
- id_dest  in  4  destination register of the ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- exe_branch_taken  in  1  branch resolved taken in EXE
- mem_ready  in  1  data memory can advance this cycle
- hazard  out  1  RAW hazard on the ID instruction
- freeze  out  1  hold PC and the IF/ID register
- flush  out  1  clear the IF/ID and ID/EXE registers
- pipe_stall  out  1  whole pipeline held for memory
- exe_dest_q  out  4  shadow EXE destination
- exe_wb_en_q  out  1  shadow EXE write-enable
- exe_mem_r_en_q  out  1  shadow EXE load flag
- mem_dest_q  out  4  shadow MEM destination
- mem_wb_en_q  out  1  shadow MEM write-enable
- stall_count  out  STALL_CNT_W  cycles with freeze=1

Behaviour:
- Reset (rst=1 at posedge):
  - Both shadow slots become invalid; all shadow fields become 0.
  - stall_count becomes 0.
  - With slots invalid and branch_taken=0, hazard, freeze and flush evaluate to 0. pipe_stall still follows !mem_ready.
  - Reset applied mid-stall or mid-flush wins unconditionally.
- Shadow slots:
  - EXE slot: {v, dest, wb_en, mem_r_en}. MEM slot: {v, dest, wb_en}.
  - Each `*_q` output reads 0 when its slot is invalid.
- Slot advance, only when mem_ready=1:
  - MEM slot <= EXE slot (the load flag is dropped).
  - EXE slot <= bubble (v=0) if flush=1, hazard=1 or id_valid=0; otherwise EXE slot <= {1, id_dest, id_wb_en, id_mem_r_en}.
- mem_ready=0: both slots hold, pipe_stall=1, flush forced to 0.
- Source match, combinational; match(s) is 1 when:
  - FORWARD_EN=0: (exe.v & exe.wb_en & exe.dest==s) or (mem.v & mem.wb_en & mem.dest==s).
  - FORWARD_EN=1: exe.v & exe.mem_r_en & exe.wb_en & exe.dest==s.
- hazard = id_valid & !flush & (match(id_src1) | (id_two_src & match(id_src2))).
  - A match in both slots still produces a single hazard=1.
- flush = exe_branch_taken & mem_ready.
  - Flush has priority over hazard in the same cycle: hazard=0, EXE gets a bubble.
- freeze = hazard | pipe_stall. freeze and flush may both be 1 only if that is impossible by construction; it is, since flush requires mem_ready=1.
- Latency:
  - hazard, flush and freeze are combinational from their inputs and slot state.
  - Slot state updates one cycle after the ID instruction is accepted.
- stall_count:
  - +1 on every posedge where freeze=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Rules on the ID side:
  - No hazard is raised while id_valid=0, even when the source fields match.
  - Register 4'd0 is not special; an id_dest/id_src equal to 0 matches normally.

Test Plan:
- Reset, then check state: rst=1 for 2 cycles with mem_ready=1 -> hazard=freeze=flush=0, stall_count=0, exe_dest_q=mem_dest_q=0.
- EXE-slot RAW, FORWARD_EN=0: accept {dest=3, wb_en=1}, next cycle present id_src1=3 -> hazard=1, freeze=1 for 2 cycles (EXE then MEM match), then hazard=0; stall_count=2.
- Load-use, FORWARD_EN=1:
  - Accept a load {dest=5, wb_en=1, mem_r_en=1}, then id_src2=5 with id_two_src=1 -> hazard=1 for exactly 1 cycle.
  - Same sequence with id_two_src=0 -> hazard=0.
- Branch beats hazard: EXE holds {dest=2, wb_en=1}, id_src1=2, exe_branch_taken=1 -> flush=1, hazard=0, exe_wb_en_q=0 on the next cycle.
- Memory stall: mem_ready=0 for 3 cycles with exe_branch_taken=1 -> pipe_stall=freeze=1, flush=0, slots unchanged; mem_ready=1 -> flush=1 in that cycle; stall_count +3.
- Counter saturation: STALL_CNT_W=4, hold mem_ready=0 for 20 cycles -> stall_count stays at 15.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: RAW/branch/memory-stall control for ID/EXE with shadow EXE/MEM slots and saturating stall counter
module hazard_detection_unit #(
  parameter int FORWARD_EN = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [3:0]             id_src1,
  input  logic [3:0]             id_src2,
  input  logic                   id_two_src,
  input  logic [3:0]             id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic                   exe_branch_taken,
  input  logic                   mem_ready,
  output logic                   hazard,
  output logic                   freeze,
  output logic                   flush,
  output logic                   pipe_stall,
  output logic [3:0]             exe_dest_q,
  output logic                   exe_wb_en_q,
  output logic                   exe_mem_r_en_q,
  output logic [3:0]             mem_dest_q,
  output logic                   mem_wb_en_q,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic exe_v, exe_wb, exe_mr, mem_v, mem_wb;
  logic [3:0] exe_dest, mem_dest;
  logic m1, m2;
  function automatic logic match(input logic [3:0] s);
    return FORWARD_EN != 0 ? (exe_v & exe_mr & exe_wb & (exe_dest == s))
                           : (exe_v & exe_wb & (exe_dest == s)) | (mem_v & mem_wb & (mem_dest == s));
  endfunction
  always_comb begin
    m1 = match(id_src1);
    m2 = match(id_src2);
    pipe_stall = !mem_ready;
    flush = exe_branch_taken & mem_ready;
    hazard = id_valid & !flush & (m1 | (id_two_src & m2));
    freeze = hazard | pipe_stall;
    exe_dest_q = exe_v ? exe_dest : 4'd0;
    exe_wb_en_q = exe_v & exe_wb;
    exe_mem_r_en_q = exe_v & exe_mr;
    mem_dest_q = mem_v ? mem_dest : 4'd0;
    mem_wb_en_q = mem_v & mem_wb;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {exe_v, exe_dest, exe_wb, exe_mr} <= '0;
      {mem_v, mem_dest, mem_wb} <= '0;
      stall_count <= '0;
    end else begin
      if (mem_ready) begin
        {mem_v, mem_dest, mem_wb} <= {exe_v, exe_dest, exe_wb};
        {exe_v, exe_dest, exe_wb, exe_mr} <= (flush | hazard | !id_valid) ? 7'd0 : {1'b1, id_dest, id_wb_en, id_mem_r_en};
      end
      if (freeze && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
endmodule
